// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - repeats a fixed pattern MSB-first on a valid/ready bit stream with idle gaps
// Optional abort input is enabled by defining SEQ_GEN_ABORT_EN.
module sequence_generator #(
  parameter int                   SEQ_WIDTH   = 4,
  parameter logic [SEQ_WIDTH-1:0] SEQ_PATTERN = 4'b1001,
  parameter int                   GAP_LEN     = 2,
  parameter int                   CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] repeat_cnt,
`ifdef SEQ_GEN_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 out_stream,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (SEQ_WIDTH > 1) ? $clog2(SEQ_WIDTH) : 1;
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [IW-1:0] IDX_MSB  = IW'(SEQ_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d, idx_dec;
  logic [CNT_WIDTH-1:0] copies_q, copies_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_stream_q, out_stream_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abort_w;

`ifdef SEQ_GEN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign idx_dec = idx_q - 1'b1;

  // copies_q counts the copies still owed after the one currently on the wire
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    copies_d     = copies_q;
    gap_d        = gap_q;
    out_valid_d  = out_valid_q;
    out_stream_d = out_stream_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (repeat_cnt != '0) begin
            state_d      = S_SEND;
            idx_d        = IDX_MSB;
            copies_d     = repeat_cnt - 1'b1;
            out_valid_d  = 1'b1;
            out_stream_d = SEQ_PATTERN[IDX_MSB];
            busy_d       = 1'b1;
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (abort_w) begin
          state_d      = S_FIN;
          out_valid_d  = 1'b0;
          out_stream_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end else if (out_ready) begin
          if (idx_q != '0) begin
            idx_d        = idx_dec;
            out_stream_d = SEQ_PATTERN[idx_dec];
          end else if (copies_q == '0) begin
            state_d      = S_FIN;
            out_valid_d  = 1'b0;
            out_stream_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            copies_d = copies_q - 1'b1;
            if (GAP_LEN > 0) begin
              state_d      = S_GAP;
              gap_d        = GAP_LAST;
              out_valid_d  = 1'b0;
              out_stream_d = 1'b0;
            end else begin
              idx_d        = IDX_MSB;
              out_stream_d = SEQ_PATTERN[IDX_MSB];
            end
          end
        end
      end
      S_GAP: begin
        if (abort_w) begin
          state_d      = S_FIN;
          out_valid_d  = 1'b0;
          out_stream_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end else if (gap_q == '0) begin
          state_d      = S_SEND;
          idx_d        = IDX_MSB;
          out_valid_d  = 1'b1;
          out_stream_d = SEQ_PATTERN[IDX_MSB];
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        out_valid_d  = 1'b0;
        out_stream_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      copies_q     <= '0;
      gap_q        <= '0;
      out_valid_q  <= 1'b0;
      out_stream_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      copies_q     <= copies_d;
      gap_q        <= gap_d;
      out_valid_q  <= out_valid_d;
      out_stream_q <= out_stream_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_stream = out_stream_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - scoreboard bench for sequence_generator (abort test under SEQ_GEN_ABORT_EN)
module tb_sequence_generator;

  localparam int         W    = 4;
  localparam logic [3:0] PAT  = 4'b1001;
  localparam int         GAP  = 2;
  localparam int         CW   = 8;
  localparam int         MAXC = 600;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] repeat_cnt = '0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_stream, busy, done;
`ifdef SEQ_GEN_ABORT_EN
  logic          abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int stalls = 0;
  int gap_run = 0;
  bit abort_flag = 1'b0;
  bit exp_bits[$];
  int exp_n[$];

  sequence_generator #(.SEQ_WIDTH(W), .SEQ_PATTERN(PAT), .GAP_LEN(GAP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .repeat_cnt(repeat_cnt),
`ifdef SEQ_GEN_ABORT_EN
    .abort(abort),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .out_stream(out_stream),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected stream and burst records as the DUT presents them
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_bits.delete();
      exp_n.delete();
      busy_cnt = 0;
      stalls   = 0;
      gap_run  = 0;
    end else begin
      if (!out_valid) check("stream_zero_when_idle", out_stream, 0);
      if (done) check("busy_low_with_done", busy, 0);
      if (busy) busy_cnt++;
      if (out_valid && !out_ready) stalls++;
      if (busy && !out_valid) gap_run++;
      if (out_valid && out_ready) begin
        if (exp_bits.size() == 0) begin
          check("extra_bit", 1, 0);
        end else begin
          check("bit", out_stream, exp_bits.pop_front());
        end
        if (gap_run > 0) check("gap_len", gap_run, GAP);
        gap_run = 0;
      end
      if (done) begin
        if (exp_n.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          int n, eb;
          n  = exp_n.pop_front();
          eb = (n == 0) ? 0 : n * W + (n - 1) * GAP + stalls;
          check("bits_left_at_done", exp_bits.size(), 0);
          if (!abort_flag) check("busy_cycles", busy_cnt, eb);
        end
        abort_flag = 1'b0;
        busy_cnt = 0;
        stalls   = 0;
        gap_run  = 0;
        done_cnt++;
      end
    end
  end

  task automatic issue(input int n);
    start      = 1'b1;
    repeat_cnt = CW'(n);
    for (int c = 0; c < n; c++)
      for (int b = W - 1; b >= 0; b--) exp_bits.push_back(PAT[b]);
    exp_n.push_back(n);
  endtask

  // Called at posedge+1 with DUT idle; returns at posedge+1 with DUT idle again.
  task automatic run_burst(input int n, input int mode, input bit repulse);
    int d0, cyc;
    d0 = done_cnt;
    out_ready = (mode == 0) ? 1'b1 : 1'($urandom);
    issue(n);
    @(posedge clk); #1;
    start = 1'b0;
    repeat_cnt = CW'($urandom);
    if (n == 0) begin
      @(negedge clk);
      check("zero_done_latency", done, 1);
      check("zero_busy", busy, 0);
      @(posedge clk); #1;
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < MAXC) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom);
      endcase
      if (repulse && cyc == 3) begin
        start = 1'b1;
        repeat_cnt = CW'(5);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int d0, cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_stream", out_stream, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_burst(2, 0, 1'b0);
    run_burst(2, 1, 1'b0);
    run_burst(0, 0, 1'b0);
    run_burst(3, 2, 1'b1);
    for (int i = 0; i < 6; i++) run_burst(int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), 1'b0);

    // Reset in the middle of a SEND phase: outputs drop at once, no done
    d0 = done_cnt;
    out_ready = 1'b1;
    issue(3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, d0);
    run_burst(1, 0, 1'b0);

`ifdef SEQ_GEN_ABORT_EN
    d0 = done_cnt;
    out_ready = 1'b1;
    issue(3);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(busy && !out_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_gap", int'(busy && !out_valid), 1);
    abort = 1'b1;
    abort_flag = 1'b1;
    exp_bits.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_done", done, 1);
    check("abort_valid", out_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_done_once", done_cnt, d0 + 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_bits.size() + exp_n.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
